// File: rtl/hs_ram_arbiter.sv
// hs_ram_arbiter: shares the core's hiscore-visible work RAM port between the
// running CPU and the hiscore engine, one byte access per engine request.
//
// Ports:
//   clk_sys, reset_n           clock, async active-low reset
//   req/we/addr/wdata          engine request (sampled on acceptance)
//   ack/err/rdata              engine completion pulse, timeout pulse, read data
//   pause_req/pause_ack        CPU pause handshake
//   ram_addr/ram_wdata/ram_we  core RAM port outputs
//   ram_rdata                  core RAM port read data
//   busy                       high whenever the FSM is not idle
module hs_ram_arbiter #(
  parameter int AW      = 12,
  parameter int SETTLE  = 4,
  parameter int RD_LAT  = 1,
  parameter int HOLD    = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic          ack,
  output logic          err,
  output logic [7:0]    rdata,
  output logic          pause_req,
  input  logic          pause_ack,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_wdata,
  output logic          ram_we,
  input  logic [7:0]    ram_rdata,
  output logic          busy
);

  localparam int MAX_TH = (TIMEOUT > HOLD) ? TIMEOUT : HOLD;
  localparam int MAXC   = (MAX_TH > SETTLE) ? MAX_TH : SETTLE;
  localparam int CW     = $clog2(MAXC + 1);

  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] ST_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0] RL_LAST = CW'(RD_LAT - 1);
  localparam logic [CW-1:0] HD_LAST = CW'(HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PWAIT,
    S_SETTLE,
    S_ACCESS,
    S_RWAIT,
    S_DONE,
    S_HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic            pause_q, pause_d;
  logic [7:0]      rdata_q, rdata_d;
  logic [AW-1:0]   ram_addr_q, ram_addr_d;
  logic [7:0]      ram_wdata_q, ram_wdata_d;
  logic            err_d;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      pause_q     <= 1'b0;
      rdata_q     <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      pause_q     <= pause_d;
      rdata_q     <= rdata_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    pause_d     = pause_q;
    rdata_d     = rdata_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    err_d       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          pause_d = 1'b1;
          state_d = S_PWAIT;
        end
      end
      S_PWAIT: begin
        if (pause_ack) begin
          cnt_d   = '0;
          state_d = S_SETTLE;
        end else if (cnt_q == TO_LAST) begin
          // err is a Mealy pulse on the last allowed cycle
          err_d   = 1'b1;
          pause_d = 1'b0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      S_SETTLE: begin
        if (!pause_ack) begin
          cnt_d   = '0;
          state_d = S_PWAIT;
        end else if (cnt_q == ST_LAST) begin
          ram_addr_d  = addr_q;
          ram_wdata_d = wdata_q;
          state_d     = S_ACCESS;
        end
      end
      S_ACCESS: begin
        cnt_d = '0;
        if (!pause_ack) begin
          state_d = S_PWAIT;
        end else if (we_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RWAIT;
        end
      end
      S_RWAIT: begin
        if (!pause_ack) begin
          cnt_d   = '0;
          state_d = S_PWAIT;
        end else if (cnt_q == RL_LAST) begin
          rdata_d = ram_rdata;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = '0;
          if (pause_ack) begin
            // CPU still halted: skip the pause wait and settle window
            ram_addr_d  = addr;
            ram_wdata_d = wdata;
            state_d     = S_ACCESS;
          end else begin
            state_d = S_PWAIT;
          end
        end else if (cnt_q == HD_LAST) begin
          pause_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        pause_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign ack       = (state_q == S_DONE);
  assign err       = err_d;
  assign rdata     = rdata_q;
  assign pause_req = pause_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  // gated by pause_ack so an external override never lands a write
  assign ram_we    = (state_q == S_ACCESS) & we_q & pause_ack;
  assign busy      = (state_q != S_IDLE);

endmodule
